// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush request and response bundle between the pipeline stages and pipe_stall_ctrl.
// The master side is the pipeline; the slave side is the controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned PERF_W = 32
);
  logic              stallreq_from_if;
  logic              stallreq_from_id;
  logic              stallreq_from_ex;
  logic              stallreq_from_mem;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc;

  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_busy;
  logic              mc_done;
  logic              bus_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
           ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
    input  stall, flush, new_pc, mc_busy, mc_done, bus_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
           ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
    output stall, flush, new_pc, mc_busy, mc_done, bus_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: prioritised stall vector, multi-cycle EX sequencing,
// exception flush, MEM bus watchdog and saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned PERF_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_stall_ctrl_if.slave      bus
);

  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic              timeout_q;
  logic [PERF_W-1:0] perf_q;

  logic       start_long;
  logic       start_short;
  logic       run_done;
  logic       ex_hold;
  logic [5:0] stall_c;

  // Decode multi-cycle events and the prioritised stall vector from state and requests.
  always_comb begin
    start_long  = 1'b0;
    start_short = 1'b0;
    run_done    = 1'b0;
    ex_hold     = 1'b0;
    stall_c     = 6'b000000;

    if (state_q == IDLE && bus.ex_mc_start) begin
      start_long  = (bus.ex_mc_cycles >= CNT_W'(2));
      start_short = (bus.ex_mc_cycles <  CNT_W'(2));
    end
    run_done = (state_q == RUN) && !bus.stallreq_from_mem && (cnt_q == CNT_W'(1));
    ex_hold  = bus.stallreq_from_ex || start_long ||
               ((state_q == RUN) && (cnt_q > CNT_W'(1)));

    if (bus.flush_req)              stall_c = 6'b000000;
    else if (bus.stallreq_from_mem) stall_c = 6'b011111;
    else if (ex_hold)               stall_c = 6'b001111;
    else if (bus.stallreq_from_id)  stall_c = 6'b000111;
    else if (bus.stallreq_from_if)  stall_c = 6'b000011;
  end

  // Outputs are all forced low while reset is asserted.
  always_comb begin
    bus.stall        = 6'b000000;
    bus.flush        = 1'b0;
    bus.new_pc       = 32'h0;
    bus.mc_busy      = 1'b0;
    bus.mc_done      = 1'b0;
    bus.bus_timeout  = 1'b0;
    bus.stall_cycles = '0;
    if (!rst) begin
      bus.stall        = stall_c;
      bus.flush        = bus.flush_req;
      bus.new_pc       = bus.flush_req ? bus.flush_pc : 32'h0;
      bus.mc_busy      = (state_q == RUN);
      bus.mc_done      = !bus.flush_req && (start_short || run_done);
      bus.bus_timeout  = timeout_q;
      bus.stall_cycles = perf_q;
    end
  end

  // Multi-cycle FSM, watchdog and performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      if (bus.flush_req) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_long) begin
              state_q <= RUN;
              cnt_q   <= bus.ex_mc_cycles - CNT_W'(1);
            end
          end
          RUN: begin
            // A MEM stall freezes the countdown so EX does not retire under a held pipe.
            if (!bus.stallreq_from_mem) begin
              if (cnt_q <= CNT_W'(1)) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end

      timeout_q <= 1'b0;
      if (bus.stallreq_from_mem && !bus.flush_req) begin
        if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout_q <= 1'b1;
          wd_q      <= '0;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
      end else begin
        wd_q <= '0;
      end

      if (stall_c[0] && (perf_q != {PERF_W{1'b1}})) begin
        perf_q <= perf_q + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; a second instance with a 4-bit
// performance counter shares the same stimulus to exercise saturation.
module tb_pipe_stall_ctrl;

  localparam int unsigned CNT_W = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(32)) ifa ();
  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(4))  ifb ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4), .PERF_W(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4), .PERF_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  assign ifb.stallreq_from_if  = ifa.stallreq_from_if;
  assign ifb.stallreq_from_id  = ifa.stallreq_from_id;
  assign ifb.stallreq_from_ex  = ifa.stallreq_from_ex;
  assign ifb.stallreq_from_mem = ifa.stallreq_from_mem;
  assign ifb.ex_mc_start       = ifa.ex_mc_start;
  assign ifb.ex_mc_cycles      = ifa.ex_mc_cycles;
  assign ifb.flush_req         = ifa.flush_req;
  assign ifb.flush_pc          = ifa.flush_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_pipe(input string tag, input logic [5:0] st, input logic fl,
                          input logic [31:0] pc, input logic done, input logic busy);
    chk({tag, ".stall"},   64'(ifa.stall),   64'(st));
    chk({tag, ".flush"},   64'(ifa.flush),   64'(fl));
    chk({tag, ".new_pc"},  64'(ifa.new_pc),  64'(pc));
    chk({tag, ".mc_done"}, 64'(ifa.mc_done), 64'(done));
    chk({tag, ".mc_busy"}, 64'(ifa.mc_busy), 64'(busy));
  endtask

  task automatic req(input logic i, input logic d, input logic e, input logic m);
    ifa.stallreq_from_if  = i;
    ifa.stallreq_from_id  = d;
    ifa.stallreq_from_ex  = e;
    ifa.stallreq_from_mem = m;
  endtask

  task automatic mc(input logic start, input logic [CNT_W-1:0] n);
    ifa.ex_mc_start  = start;
    ifa.ex_mc_cycles = n;
  endtask

  task automatic fl(input logic r, input logic [31:0] pc);
    ifa.flush_req = r;
    ifa.flush_pc  = pc;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every request asserted
    rst = 1'b1;
    req(1'b1, 1'b1, 1'b1, 1'b1);
    mc(1'b1, CNT_W'(4));
    fl(1'b1, 32'hdead_beef);
    nxt();
    nxt();
    chk_pipe("rst_hold", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_hold.timeout", 64'(ifa.bus_timeout), 64'(0));
    chk("rst_hold.perf_a", 64'(ifa.stall_cycles), 64'(0));
    chk("rst_hold.perf_b", 64'(ifb.stall_cycles), 64'(0));
    req(1'b0, 1'b0, 1'b0, 1'b0);
    mc(1'b0, CNT_W'(0));
    fl(1'b0, 32'h0);
    nxt();
    rst = 1'b0;
    #1;
    chk_pipe("post_rst", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst.perf", 64'(ifa.stall_cycles), 64'(0));

    // Stall priority
    req(1'b1, 1'b1, 1'b0, 1'b1); #1;
    chk_pipe("prio_mem", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    req(1'b1, 1'b1, 1'b0, 1'b0); #1;
    chk_pipe("prio_id", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    req(1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk_pipe("prio_if", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    req(1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk_pipe("prio_ex", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    req(1'b1, 1'b0, 1'b0, 1'b0);
    fl(1'b1, 32'h0000_0040); #1;
    chk_pipe("prio_flush", 6'b000000, 1'b1, 32'h40, 1'b0, 1'b0);
    nxt();
    req(1'b0, 1'b0, 1'b0, 1'b0);
    fl(1'b0, 32'h0000_0040); #1;
    chk_pipe("idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("prio.perf", 64'(ifa.stall_cycles), 64'(4));

    // Multi-cycle N=4
    mc(1'b1, CNT_W'(4)); #1;
    chk_pipe("mc4_t0", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    mc(1'b0, CNT_W'(4)); #1;
    chk_pipe("mc4_t1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mc4_t2", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mc4_t3", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1);
    nxt();
    chk_pipe("mc4_t4", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Multi-cycle N=1 and N=0 retire immediately
    mc(1'b1, CNT_W'(1)); #1;
    chk_pipe("mc1_t0", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
    nxt();
    mc(1'b1, CNT_W'(0)); #1;
    chk_pipe("mc0_t0", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
    nxt();
    mc(1'b0, CNT_W'(0)); #1;
    chk_pipe("mc0_t1", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // MEM stall during RUN freezes the countdown
    mc(1'b1, CNT_W'(4)); #1;
    chk_pipe("mcm_t0", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    mc(1'b0, CNT_W'(0));
    req(1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk_pipe("mcm_t1", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mcm_t2", 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    req(1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk_pipe("mcm_t3", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mcm_t4", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mcm_t5", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1);
    nxt();
    chk_pipe("mcm_t6", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Flush mid-RUN abandons the op
    mc(1'b1, CNT_W'(10)); #1;
    chk_pipe("mcf_t0", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    mc(1'b0, CNT_W'(0)); #1;
    chk_pipe("mcf_t1", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    chk_pipe("mcf_t2", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    nxt();
    fl(1'b1, 32'h0000_0100); #1;
    chk_pipe("mcf_t3", 6'b000000, 1'b1, 32'h100, 1'b0, 1'b1);
    nxt();
    fl(1'b0, 32'h0); #1;
    chk_pipe("mcf_t4", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    chk_pipe("mcf_t5", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Flush beats a simultaneous start
    mc(1'b1, CNT_W'(5));
    fl(1'b1, 32'h0000_0200); #1;
    chk_pipe("fls_t0", 6'b000000, 1'b1, 32'h200, 1'b0, 1'b0);
    nxt();
    mc(1'b1, CNT_W'(1)); #1;
    chk_pipe("fls_short", 6'b000000, 1'b1, 32'h200, 1'b0, 1'b0);
    nxt();
    mc(1'b0, CNT_W'(0));
    fl(1'b0, 32'h0); #1;
    chk_pipe("fls_t2", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Watchdog and performance counter from a clean reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("wd.perf0", 64'(ifa.stall_cycles), 64'(0));
    chk("wd.stall", 64'(ifa.stall), 64'(6'b011111));
    for (int i = 1; i <= 10; i++) begin
      nxt();
      if (i == 10) req(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("wd.timeout_%0d", i), 64'(ifa.bus_timeout), 64'((i == 4) || (i == 8)));
    end
    #1;
    chk("wd.perf_a", 64'(ifa.stall_cycles), 64'(10));
    chk("wd.perf_b", 64'(ifb.stall_cycles), 64'(10));
    nxt();
    chk("wd.idle_timeout", 64'(ifa.bus_timeout), 64'(0));

    // Saturation of the narrow counter
    req(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) nxt();
    req(1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("sat.perf_a", 64'(ifa.stall_cycles), 64'(20));
    chk("sat.perf_b", 64'(ifb.stall_cycles), 64'(15));
    nxt();
    chk("sat.hold_b", 64'(ifb.stall_cycles), 64'(15));
    rst = 1'b1;
    nxt();
    chk("sat.rst_b", 64'(ifb.stall_cycles), 64'(0));
    rst = 1'b0;
    nxt();
    chk("sat.after_rst_a", 64'(ifa.stall_cycles), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. Merges stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector consumed by the pc/if_id/id_ex/ex_mem/mem_wb registers. Sequences multi-cycle EX operations (mult-acc, div) by holding `id_ex` for a programmed number of cycles. Also generates exception flushes, a MEM bus watchdog and a stall-cycle performance counter.

Parameters:
- `CNT_W`, 6, width of the multi-cycle length and down-counter.
- `TIMEOUT`, 255, consecutive MEM-stall cycles before `bus_timeout` fires.
- `PERF_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `stallreq_from_if`  in  1  fetch bus wait.
- `stallreq_from_id`  in  1  load-use hazard.
- `stallreq_from_ex`  in  1  generic EX hold, single-cycle request.
- `stallreq_from_mem`  in  1  data bus wait.
- `ex_mc_start`  in  1  EX has issued a multi-cycle op this cycle.
- `ex_mc_cycles`  in  CNT_W  total EX occupancy N of that op.
- `flush_req`  in  1  exception/eret from MEM.
- `flush_pc`  in  32  handler/return address.
- `stall`  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
- `flush`  out  1  clear all pipeline registers.
- `new_pc`  out  32  PC to load when `flush`=1.
- `mc_busy`  out  1  multi-cycle op in progress.
- `mc_done`  out  1  EX result valid this cycle.
- `bus_timeout`  out  1  one-cycle pulse on watchdog expiry.
- `stall_cycles`  out  PERF_W  saturating count of cycles with `stall[0]`=1.

Behaviour:
- `stall`, `flush`, `new_pc` and `mc_done` are combinational from state plus inputs, so the pipeline registers see them in the same cycle. All state updates occur on `posedge clk`.
- Reset (`rst`=1 at an edge) sets state to IDLE and clears `cnt`, the watchdog count, `stall_cycles` and `bus_timeout`. While `rst`=1, all outputs are forced to 0, including `stall`=000000.
- Stall priority (highest first):
  - `flush_req` → `stall`=000000, `flush`=1, `new_pc`=`flush_pc`.
  - MEM → 011111.
  - EX hold → 001111. EX hold means `stallreq_from_ex`, OR (IDLE & `ex_mc_start` & N≥2), OR (RUN & `cnt`>1).
  - ID → 000111.
  - IF → 000011.
  - Otherwise 000000.
- When `flush`=0, `new_pc`=0.
- States: IDLE, RUN.
- IDLE:
  - `ex_mc_start` with N≥2: load `cnt`=N-1 and go to RUN. `stall`=001111 in the start cycle.
  - N=0 or 1: no state change, `mc_done`=1 in the start cycle.
  - `ex_mc_start` is ignored in RUN.
- RUN:
  - `mc_busy`=1.
  - If `stallreq_from_mem`=1, `cnt` holds and `mc_done`=0 (frozen).
  - Otherwise `cnt` decrements. When `cnt`==1 that cycle: `mc_done`=1, EX stall released, go to IDLE.
  - Net result: EX occupancy is exactly N cycles plus any MEM-stall cycles.
- Flush in any state: next state IDLE, `cnt`=0, multi-cycle op abandoned, no `mc_done`. Flush beats simultaneous `ex_mc_start`; that start is dropped.
- Watchdog:
  - Counts consecutive cycles with `stallreq_from_mem`=1 and `flush_req`=0.
  - Resets to 0 when the request drops or on flush.
  - On the edge where the count reaches `TIMEOUT`, `bus_timeout` is registered high for one cycle, then the count clears (re-arms).
- `stall_cycles` increments on each edge where `stall[0]`=1, and saturates at all-ones.

Test Plan:
- Reset: hold `rst` 2 cycles with all requests high → all outputs 0. After release with no requests → `stall`=000000, `stall_cycles`=0.
- Priority: `stallreq_from_if`+`id`+`mem` together → `stall`=011111. Drop mem → 000111. Drop id → 000011. Add `flush_req`, `flush_pc`=0x00000040 → `stall`=000000, `flush`=1, `new_pc`=0x40.
- Multi-cycle N=4: pulse `ex_mc_start` at cycle t → `stall`=001111 for cycles t..t+2, `mc_done`=1 and `stall`=000000 at t+3, `mc_busy`=1 for t+1..t+3. N=1 → `mc_done`=1 at t, no stall.
- MEM during RUN: N=4 with `stallreq_from_mem` high for 2 cycles at t+1 → `stall`=011111 during those cycles, `cnt` frozen, `mc_done` at t+5.
- Flush mid-RUN: N=10, `flush_req` at t+3 → `flush`=1 that cycle, state IDLE at t+4, `mc_done` never asserted, `stall`=000000 at t+4.
- Watchdog + perf: `TIMEOUT`=4, mem stall held 10 cycles → `bus_timeout` pulses after 4th and 8th cycles, `stall_cycles`=10. Saturation check with `PERF_W`=4: 20 stalled cycles → 15.
